key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 26'd50_000_000, hold time in clocks before a press is classified long (1 s at 50 MHz).
REQ-002 SHALL have parameter REPEAT_CYC, default 26'd10_000_000, auto-repeat period in clocks while long-held (200 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_flag, input, 1, one-cycle strobe marking a new debounced key state.
REQ-006 SHALL have port key_value, input, 1, debounced key level qualified by key_flag; 0 = pressed, 1 = released.
REQ-007 SHALL have port press_pulse, output, 1, one-cycle pulse on accepted press.
REQ-008 SHALL have port release_pulse, output, 1, one-cycle pulse on accepted release.
REQ-009 SHALL have port short_pulse, output, 1, one-cycle pulse on release before LONG_CYC elapsed.
REQ-010 SHALL have port long_pulse, output, 1, one-cycle pulse when hold reaches LONG_CYC.
REQ-011 SHALL have port repeat_pulse, output, 1, one-cycle pulse every REPEAT_CYC while long-held.
REQ-012 SHALL have port key_held, output, 1, high while state is not IDLE.
REQ-013 SHALL have port press_count, output, 8, count of accepted presses.

Function
REQ-014 SHALL implement states IDLE, PRESSED, LONG with a 26-bit hold counter.
REQ-015 SHALL sample key_value only in cycles where key_flag=1; key_value is ignored otherwise.
REQ-016 IDLE: key_flag=1 and key_value=0 -> PRESSED, counter cleared to 0, press_pulse asserted the next cycle, press_count incremented.
REQ-017 PRESSED: counter increments each cycle; key_flag=1 and key_value=1 -> IDLE with release_pulse and short_pulse asserted together the next cycle.
REQ-018 PRESSED: counter equal to LONG_CYC-1 with no release that cycle -> LONG, counter cleared, long_pulse asserted the next cycle.
REQ-019 LONG: key_flag=1 and key_value=1 -> IDLE with release_pulse only; short_pulse stays 0.
REQ-020 SHALL ignore a flag whose key_value matches the current state (value 1 in IDLE, value 0 in PRESSED or LONG) with no pulses and no state change.
REQ-021 Simultaneous release and counter=LONG_CYC-1 in PRESSED: release wins; short_pulse and release_pulse asserted; long_pulse stays 0.
REQ-022 Simultaneous release and repeat expiry in LONG: release wins; repeat_pulse stays 0.
REQ-023 All outputs SHALL be registered; each pulse is high for exactly one clock, one cycle after the triggering cycle.
REQ-024 press_count SHALL wrap 8'd255 -> 8'd0 without saturation.
REQ-025 key_held SHALL be registered and go high in the same cycle as press_pulse and low in the same cycle as release_pulse.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, counter 0, press_count 0, and all pulse outputs and key_held to 0; rst takes priority over key_flag.
REQ-027 Reset during PRESSED or LONG SHALL emit no release_pulse; a key still held after reset is not reported until a release flag followed by a press flag.

Configuration
REQ-028 With macro KEY_REPEAT_EN defined, LONG SHALL increment the counter and, at REPEAT_CYC-1, pulse repeat_pulse and clear the counter.
REQ-029 Without KEY_REPEAT_EN, repeat_pulse SHALL be tied to 0, the counter SHALL hold in LONG, and all other behaviour SHALL be unchanged.

Verification (LONG_CYC=10, REPEAT_CYC=4, KEY_REPEAT_EN defined unless noted)
REQ-030 Press flag at cycle 0, release flag at cycle 5 -> press_pulse and key_held rise at cycle 1; release_pulse and short_pulse at cycle 6; no long_pulse; press_count=1.
REQ-031 Press flag at cycle 0, release flag at cycle 25 -> long_pulse at cycle 11; repeat_pulse at cycles 15, 19, 23; release_pulse at 26 with short_pulse=0.
REQ-032 Same stimulus without KEY_REPEAT_EN -> long_pulse at cycle 11; repeat_pulse never asserted; release_pulse at 26.
REQ-033 Press flag at cycle 0, release flag at cycle 10 -> short_pulse and release_pulse at cycle 11; long_pulse stays 0.
REQ-034 256 press/release pairs -> press_count reads 0 after the last press; key_value=0 toggling with key_flag=0 -> no pulses.
REQ-035 Press at cycle 0, rst high at cycle 3, press flag at cycle 6 while IDLE-ignored check: release flag at cycle 6 -> no pulses; press flag at cycle 8 -> press_pulse at 9, press_count=1.

Source files
------------

// File: rtl/key_event_if.sv
// key_event_if -- bundles the debounced key input strobe and the decoded
// key-event outputs of key_event_decoder.
//
// Signals:
//   key_flag      one-cycle strobe marking a new debounced key state
//   key_value     debounced key level, valid with key_flag (0 = pressed)
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   short_pulse   one-cycle pulse on a release before the long-hold time
//   long_pulse    one-cycle pulse when the hold reaches the long-hold time
//   repeat_pulse  one-cycle auto-repeat pulse while long-held
//   key_held      high while the decoder is not idle
//   press_count   8-bit wrapping count of accepted presses
//
// Modports: master drives the key inputs and observes the events,
//           slave is the decoder side.
interface key_event_if;
   logic       key_flag;
   logic       key_value;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       key_held;
   logic [7:0] press_count;

   modport master (
      output key_flag, key_value,
      input  press_pulse, release_pulse, short_pulse, long_pulse,
             repeat_pulse, key_held, press_count
   );

   modport slave (
      input  key_flag, key_value,
      output press_pulse, release_pulse, short_pulse, long_pulse,
             repeat_pulse, key_held, press_count
   );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder -- turns debounced key-state strobes into press,
// release, short-press, long-press and auto-repeat events.
//
// Parameters:
//   LONG_CYC   hold time in clocks before a press counts as long
//   REPEAT_CYC auto-repeat period in clocks while long-held
//
// Ports:
//   clk  single system clock, rising edge
//   rst  synchronous active-high reset
//   kif  key_event_if.slave: key_flag/key_value in, event pulses,
//        key_held and press_count out (all registered)
//
// Build option: define KEY_REPEAT_EN to enable auto-repeat. Without it
// repeat_pulse is held at 0 and the hold counter freezes once long-held.
module key_event_decoder #(
   parameter logic [25:0] LONG_CYC   = 26'd50_000_000,
   parameter logic [25:0] REPEAT_CYC = 26'd10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   key_event_if.slave kif
);

`ifdef KEY_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd1;
   localparam logic [1:0] ST_LONG    = 2'd2;

   localparam logic [25:0] LONG_LAST   = LONG_CYC - 26'd1;
   localparam logic [25:0] REPEAT_LAST = REPEAT_CYC - 26'd1;

   logic [1:0]  state;
   logic [25:0] hold_cnt;
   logic [7:0]  count_q;
   logic        press_q, release_q, short_q, long_q, repeat_q, held_q;

   // A flag is only meaningful when it reports the opposite of the current
   // state; a matching value is silently ignored.
   logic rel_flag, press_flag;
   assign rel_flag   = kif.key_flag &&  kif.key_value;
   assign press_flag = kif.key_flag && !kif.key_value;

   // NOTE: all state below is sequential and uses non-blocking assignment so
   // every register updates from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         count_q   <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         // Pulses default low so each is high for exactly one clock.
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (press_flag) begin
                  state    <= ST_PRESSED;
                  hold_cnt <= '0;
                  press_q  <= 1'b1;
                  held_q   <= 1'b1;
                  count_q  <= count_q + 8'd1;   // wraps 255 -> 0
               end
            end

            ST_PRESSED: begin
               // Release is tested first so it wins over a coincident
               // long-hold expiry.
               if (rel_flag) begin
                  state     <= ST_IDLE;
                  hold_cnt  <= '0;
                  release_q <= 1'b1;
                  short_q   <= 1'b1;
                  held_q    <= 1'b0;
               end else if (hold_cnt == LONG_LAST) begin
                  state    <= ST_LONG;
                  hold_cnt <= '0;
                  long_q   <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 26'd1;
               end
            end

            ST_LONG: begin
               if (rel_flag) begin
                  state     <= ST_IDLE;
                  hold_cnt  <= '0;
                  release_q <= 1'b1;
                  held_q    <= 1'b0;
               end else if (REPEAT_EN) begin
                  if (hold_cnt == REPEAT_LAST) begin
                     hold_cnt <= '0;
                     repeat_q <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 26'd1;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               hold_cnt <= '0;
               held_q   <= 1'b0;
            end
         endcase
      end
   end

   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = release_q;
   assign kif.short_pulse   = short_q;
   assign kif.long_pulse    = long_q;
   assign kif.repeat_pulse  = REPEAT_EN ? repeat_q : 1'b0;
   assign kif.key_held      = held_q;
   assign kif.press_count   = count_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder -- self-checking bench for key_event_decoder with
// LONG_CYC=10 and REPEAT_CYC=4. Expectations follow KEY_REPEAT_EN.
//
// Output vector compared each cycle: {press, release, short, long, repeat, held}.
module tb_key_event_decoder;

`ifdef KEY_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   key_event_if kif ();

   key_event_decoder #(
      .LONG_CYC   (26'd10),
      .REPEAT_CYC (26'd4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       flag;
      logic       value;
      logic [5:0] exp_ev;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] events();
      return {kif.press_pulse, kif.release_pulse, kif.short_pulse,
              kif.long_pulse, kif.repeat_pulse, kif.key_held};
   endfunction

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      kif.key_flag = 1'b0;
      kif.key_value = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Press flag at cycle 0, release flag at cycle r; every cycle checked.
   task automatic run_hold(input int r);
      logic [5:0] exp;
      int         c;
      do_reset();
      for (int k = 0; k <= r + 2; k++) begin
         kif.key_flag  = (k == 0) || (k == r);
         kif.key_value = (k == 0) ? 1'b0 : (k == r) ? 1'b1 : k[0];
         step();
         c = k + 1;
         exp[5] = (c == 1);
         exp[4] = (c == r + 1);
         exp[3] = (r <= 10) && (c == r + 1);
         exp[2] = (r > 10) && (c == 11);
         exp[1] = REP && (r > 10) && (c >= 15) && ((c - 11) % 4 == 0) && (c <= r);
         exp[0] = (c >= 1) && (c <= r);
         check($sformatf("hold r=%0d cycle %0d", r, c), 32'(events()), 32'(exp));
      end
      check($sformatf("hold r=%0d count", r), 32'(kif.press_count), 32'd1);
   endtask

   initial begin
      logic [5:0] exp;
      logic [7:0] exp_cnt;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      kif.key_flag  = 1'b0;
      kif.key_value = 1'b1;

      //               rst   flag  value  {p,r,s,l,rp,h} count
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 6'b000000, 8'd0};  // reset state
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 6'b000000, 8'd0};  // release in IDLE ignored
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 8'd0};  // level without flag ignored
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'b100001, 8'd1};  // press accepted
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 6'b000001, 8'd1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 8'd1};  // press in PRESSED ignored
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 6'b011000, 8'd1};  // short release
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 8'd1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'b100001, 8'd2};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 6'b000000, 8'd0};  // reset beats release flag
      vecs[10] = '{1'b0, 1'b1, 1'b1, 6'b000000, 8'd0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 6'b100001, 8'd1};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};

      step();
      for (int i = 0; i < 13; i++) begin
         rst           = vecs[i].rst;
         kif.key_flag  = vecs[i].flag;
         kif.key_value = vecs[i].value;
         step();
         check($sformatf("vec %0d events", i), 32'(events()), 32'(vecs[i].exp_ev));
         check($sformatf("vec %0d count", i), 32'(kif.press_count), 32'(vecs[i].exp_cnt));
      end
      rst = 1'b0;

      run_hold(5);    // short press
      run_hold(10);   // release coincides with long expiry: release wins
      run_hold(11);   // just long
      run_hold(25);   // long with repeats
      run_hold(26);   // release coincides with repeat expiry

      // Press counter wraps after 256 press/release pairs.
      do_reset();
      for (int n = 1; n <= 256; n++) begin
         kif.key_flag  = 1'b1;
         kif.key_value = 1'b0;
         step();
         if (n == 255 || n == 256)
            check($sformatf("wrap press %0d", n), 32'(kif.press_count), 32'(n % 256));
         kif.key_value = 1'b1;
         step();
      end
      kif.key_flag = 1'b0;
      for (int k = 0; k < 8; k++) begin
         kif.key_value = k[0];
         step();
         check($sformatf("no flag toggle %0d", k), 32'(events()), 32'd0);
      end

      // Reset while held: stale release ignored, fresh press counted.
      do_reset();
      for (int k = 0; k <= 10; k++) begin
         int c;
         rst           = (k == 3);
         kif.key_flag  = (k == 0) || (k == 6) || (k == 8);
         kif.key_value = (k == 6);
         step();
         c = k + 1;
         exp     = 6'b000000;
         exp[5]  = (c == 1) || (c == 9);
         exp[0]  = (c >= 1 && c <= 3) || (c >= 9);
         exp_cnt = (c <= 3 || c >= 9) ? 8'd1 : 8'd0;
         check($sformatf("rst seq cycle %0d events", c), 32'(events()), 32'(exp));
         check($sformatf("rst seq cycle %0d count", c), 32'(kif.press_count), 32'(exp_cnt));
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
